cpu_axi_arbiter: RTL and testbench

Two-master to one-slave AXI arbiter sitting directly downstream of the cache miss handlers. Master 0 is the data-cache miss handler and master 1 is the instruction-cache miss handler; each issues at most one transaction at a time. The arbiter serialises their traffic onto the single CPU AXI port, with one outstanding transaction in total. It routes read data and write responses back to whichever master owns the current transaction.

---
 rtl/cpu_axi_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_cpu_axi_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_axi_arbiter.sv
// rtl/cpu_axi_arbiter.sv - two-master to one-slave AXI arbiter, one outstanding transaction
// Round-robin on ties, write before read within a master; R/W/B routed by owner.
module cpu_axi_arbiter #(
   parameter int ID_W = 4
) (
   input  logic            clk,
   input  logic            rst,
   // master 0 (data-cache miss handler)
   input  logic [ID_W-1:0] m0_arid,
   input  logic [31:0]     m0_araddr,
   input  logic [7:0]      m0_arlen,
   input  logic [2:0]      m0_arsize,
   input  logic [1:0]      m0_arburst,
   input  logic            m0_arvalid,
   output logic            m0_arready,
   output logic [ID_W-1:0] m0_rid,
   output logic [31:0]     m0_rdata,
   output logic [1:0]      m0_rresp,
   output logic            m0_rlast,
   output logic            m0_rvalid,
   input  logic            m0_rready,
   input  logic [ID_W-1:0] m0_awid,
   input  logic [31:0]     m0_awaddr,
   input  logic [7:0]      m0_awlen,
   input  logic [2:0]      m0_awsize,
   input  logic [1:0]      m0_awburst,
   input  logic            m0_awvalid,
   output logic            m0_awready,
   input  logic [31:0]     m0_wdata,
   input  logic [3:0]      m0_wstrb,
   input  logic            m0_wlast,
   input  logic            m0_wvalid,
   output logic            m0_wready,
   output logic [ID_W-1:0] m0_bid,
   output logic [1:0]      m0_bresp,
   output logic            m0_bvalid,
   input  logic            m0_bready,
   // master 1 (instruction-cache miss handler)
   input  logic [ID_W-1:0] m1_arid,
   input  logic [31:0]     m1_araddr,
   input  logic [7:0]      m1_arlen,
   input  logic [2:0]      m1_arsize,
   input  logic [1:0]      m1_arburst,
   input  logic            m1_arvalid,
   output logic            m1_arready,
   output logic [ID_W-1:0] m1_rid,
   output logic [31:0]     m1_rdata,
   output logic [1:0]      m1_rresp,
   output logic            m1_rlast,
   output logic            m1_rvalid,
   input  logic            m1_rready,
   input  logic [ID_W-1:0] m1_awid,
   input  logic [31:0]     m1_awaddr,
   input  logic [7:0]      m1_awlen,
   input  logic [2:0]      m1_awsize,
   input  logic [1:0]      m1_awburst,
   input  logic            m1_awvalid,
   output logic            m1_awready,
   input  logic [31:0]     m1_wdata,
   input  logic [3:0]      m1_wstrb,
   input  logic            m1_wlast,
   input  logic            m1_wvalid,
   output logic            m1_wready,
   output logic [ID_W-1:0] m1_bid,
   output logic [1:0]      m1_bresp,
   output logic            m1_bvalid,
   input  logic            m1_bready,
   // shared slave port
   output logic [ID_W-1:0] s_arid,
   output logic [31:0]     s_araddr,
   output logic [7:0]      s_arlen,
   output logic [2:0]      s_arsize,
   output logic [1:0]      s_arburst,
   output logic [1:0]      s_arlock,
   output logic [3:0]      s_arcache,
   output logic [2:0]      s_arprot,
   output logic            s_arvalid,
   input  logic            s_arready,
   input  logic [ID_W-1:0] s_rid,
   input  logic [31:0]     s_rdata,
   input  logic [1:0]      s_rresp,
   input  logic            s_rlast,
   input  logic            s_rvalid,
   output logic            s_rready,
   output logic [ID_W-1:0] s_awid,
   output logic [31:0]     s_awaddr,
   output logic [7:0]      s_awlen,
   output logic [2:0]      s_awsize,
   output logic [1:0]      s_awburst,
   output logic [1:0]      s_awlock,
   output logic [3:0]      s_awcache,
   output logic [2:0]      s_awprot,
   output logic            s_awvalid,
   input  logic            s_awready,
   output logic [ID_W-1:0] s_wid,
   output logic [31:0]     s_wdata,
   output logic [3:0]      s_wstrb,
   output logic            s_wlast,
   output logic            s_wvalid,
   input  logic            s_wready,
   input  logic [ID_W-1:0] s_bid,
   input  logic [1:0]      s_bresp,
   input  logic            s_bvalid,
   output logic            s_bready
);

   typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_RDATA, ST_WDATA, ST_WRESP} state_t;

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic            is_wr_q, is_wr_d;
   logic            last_owner_q, last_owner_d;
   logic [ID_W-1:0] wid_q, wid_d;

   logic req0, req1, grant;
   logic in_addr, in_rd, in_wd, in_wr;

   assign req0  = m0_arvalid | m0_awvalid;
   assign req1  = m1_arvalid | m1_awvalid;
   assign grant = (req0 & req1) ? ~last_owner_q : req1;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      is_wr_d      = is_wr_q;
      last_owner_d = last_owner_q;
      wid_d        = wid_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               owner_d = grant;
               is_wr_d = grant ? m1_awvalid : m0_awvalid;
               wid_d   = grant ? m1_awid : m0_awid;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (is_wr_q) begin
               if (s_awvalid && s_awready) state_d = ST_WDATA;
            end else if (s_arvalid && s_arready) begin
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (s_rvalid && s_rready && s_rlast) begin
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end
         end
         ST_WDATA: begin
            if (s_wvalid && s_wready && s_wlast) state_d = ST_WRESP;
         end
         ST_WRESP: begin
            if (s_bvalid && s_bready) begin
               state_d      = ST_IDLE;
               last_owner_d = owner_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         is_wr_q      <= 1'b0;
         last_owner_q <= 1'b1;
         wid_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         is_wr_q      <= is_wr_d;
         last_owner_q <= last_owner_d;
         wid_q        <= wid_d;
      end
   end

   assign in_addr = (state_q == ST_ADDR);
   assign in_rd   = (state_q == ST_RDATA);
   assign in_wd   = (state_q == ST_WDATA);
   assign in_wr   = (state_q == ST_WRESP);

   // Address and write-data fields follow the owner; handshakes are gated by state.
   assign s_arid    = owner_q ? m1_arid    : m0_arid;
   assign s_araddr  = owner_q ? m1_araddr  : m0_araddr;
   assign s_arlen   = owner_q ? m1_arlen   : m0_arlen;
   assign s_arsize  = owner_q ? m1_arsize  : m0_arsize;
   assign s_arburst = owner_q ? m1_arburst : m0_arburst;
   assign s_arlock  = 2'b00;
   assign s_arcache = 4'b0000;
   assign s_arprot  = 3'b000;
   assign s_arvalid = in_addr & ~is_wr_q & (owner_q ? m1_arvalid : m0_arvalid);
   assign m0_arready = in_addr & ~is_wr_q & ~owner_q & s_arready;
   assign m1_arready = in_addr & ~is_wr_q &  owner_q & s_arready;

   assign s_awid    = owner_q ? m1_awid    : m0_awid;
   assign s_awaddr  = owner_q ? m1_awaddr  : m0_awaddr;
   assign s_awlen   = owner_q ? m1_awlen   : m0_awlen;
   assign s_awsize  = owner_q ? m1_awsize  : m0_awsize;
   assign s_awburst = owner_q ? m1_awburst : m0_awburst;
   assign s_awlock  = 2'b00;
   assign s_awcache = 4'b0000;
   assign s_awprot  = 3'b000;
   assign s_awvalid = in_addr & is_wr_q & (owner_q ? m1_awvalid : m0_awvalid);
   assign m0_awready = in_addr & is_wr_q & ~owner_q & s_awready;
   assign m1_awready = in_addr & is_wr_q &  owner_q & s_awready;

   assign m0_rid    = s_rid;
   assign m0_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m0_rlast  = s_rlast;
   assign m1_rid    = s_rid;
   assign m1_rdata  = s_rdata;
   assign m1_rresp  = s_rresp;
   assign m1_rlast  = s_rlast;
   assign m0_rvalid = in_rd & ~owner_q & s_rvalid;
   assign m1_rvalid = in_rd &  owner_q & s_rvalid;
   assign s_rready  = in_rd & (owner_q ? m1_rready : m0_rready);

   assign s_wid     = wid_q;
   assign s_wdata   = owner_q ? m1_wdata : m0_wdata;
   assign s_wstrb   = owner_q ? m1_wstrb : m0_wstrb;
   assign s_wlast   = owner_q ? m1_wlast : m0_wlast;
   assign s_wvalid  = in_wd & (owner_q ? m1_wvalid : m0_wvalid);
   assign m0_wready = in_wd & ~owner_q & s_wready;
   assign m1_wready = in_wd &  owner_q & s_wready;

   assign m0_bid    = s_bid;
   assign m0_bresp  = s_bresp;
   assign m1_bid    = s_bid;
   assign m1_bresp  = s_bresp;
   assign m0_bvalid = in_wr & ~owner_q & s_bvalid;
   assign m1_bvalid = in_wr &  owner_q & s_bvalid;
   assign s_bready  = in_wr & (owner_q ? m1_bready : m0_bready);

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// tb/tb_cpu_axi_arbiter.sv - directed bench for cpu_axi_arbiter
// Grant table after reset plus hand-written read, write, stall and reset sequences.
module tb_cpu_axi_arbiter;
   localparam int ID_W = 4;

   logic clk, rst;
   logic [ID_W-1:0] m0_arid, m1_arid, m0_awid, m1_awid;
   logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
   logic [7:0]  m0_arlen, m1_arlen, m0_awlen, m1_awlen;
   logic [2:0]  m0_arsize, m1_arsize, m0_awsize, m1_awsize;
   logic [1:0]  m0_arburst, m1_arburst, m0_awburst, m1_awburst;
   logic m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic m0_awvalid, m1_awvalid, m0_awready, m1_awready;
   logic [ID_W-1:0] m0_rid, m1_rid, m0_bid, m1_bid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
   logic m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
   logic m0_bvalid, m1_bvalid, m0_bready, m1_bready;
   logic [ID_W-1:0] s_arid, s_awid, s_wid, s_rid, s_bid;
   logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
   logic [7:0]  s_arlen, s_awlen;
   logic [2:0]  s_arsize, s_awsize, s_arprot, s_awprot;
   logic [1:0]  s_arburst, s_awburst, s_arlock, s_awlock, s_rresp, s_bresp;
   logic [3:0]  s_arcache, s_awcache, s_wstrb;
   logic s_arvalid, s_arready, s_awvalid, s_awready;
   logic s_rlast, s_rvalid, s_rready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

   cpu_axi_arbiter #(.ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
      .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
      .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
      .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
      .m0_bready(m0_bready),
      .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
      .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
      .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
      .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
      .m1_bready(m1_bready),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
      .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   int stray = 0;

   typedef struct {
      logic m0a, m0w, m1a, m1w;
      logic ea, ew;
      logic [31:0] eaddr;
      logic e0, e1;
   } vec_t;
   vec_t tv[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic clear_inputs;
      m0_arvalid = 0; m1_arvalid = 0; m0_awvalid = 0; m1_awvalid = 0;
      m0_wvalid = 0; m1_wvalid = 0; m0_wlast = 0; m1_wlast = 0;
      m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;
      s_arready = 0; s_awready = 0; s_wready = 0;
      s_rvalid = 0; s_rlast = 0; s_bvalid = 0; s_bresp = 0;
   endtask

   task automatic do_reset;
      rst = 1;
      clear_inputs();
      tick();
      rst = 0;
   endtask

   function automatic logic any_hs;
      return m0_arready | m1_arready | m0_awready | m1_awready | m0_rvalid | m1_rvalid |
             m0_wready | m1_wready | m0_bvalid | m1_bvalid | s_arvalid | s_awvalid |
             s_rready | s_wvalid | s_bready;
   endfunction

   // Acts as the slave: waits for an AR, accepts it, returns `beats` beats.
   task automatic slave_read(input int beats, output logic [31:0] addr);
      int n = 0;
      settle();
      while (!s_arvalid && n < 20) begin
         tick();
         n++;
      end
      chk("ar_wait", 64'(n < 20), 64'd1);
      s_arready = 1;
      settle();
      addr = s_araddr;
      tick();
      for (int i = 0; i < beats; i++) begin
         s_rvalid = 1;
         s_rdata  = 32'(i);
         s_rlast  = (i == beats - 1);
         settle();
         stray += int'(m0_arready | m1_arready | s_arvalid);
         tick();
      end
      s_rvalid = 0;
      s_rlast  = 0;
      s_arready = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int acc, beat, cyc, lastbad, databad, lastok, stable;

      m0_arid = 4'd1; m1_arid = 4'd2; m0_awid = 4'd3; m1_awid = 4'd4;
      m0_arsize = 3'd2; m1_arsize = 3'd2; m0_awsize = 3'd2; m1_awsize = 3'd2;
      m0_arburst = 2'd1; m1_arburst = 2'd1; m0_awburst = 2'd1; m1_awburst = 2'd1;
      m0_arlen = 0; m1_arlen = 0; m0_awlen = 0; m1_awlen = 0;
      m0_araddr = 0; m1_araddr = 0; m0_awaddr = 0; m1_awaddr = 0;
      m0_wdata = 0; m1_wdata = 0; m0_wstrb = 4'hF; m1_wstrb = 4'hF;
      s_rid = 0; s_rdata = 0; s_rresp = 0; s_bid = 0;
      clear_inputs();
      do_reset();

      // reset state: everything quiet even with slave-side valids/readies high
      s_rvalid = 1; s_bvalid = 1; s_arready = 1; s_awready = 1; s_wready = 1;
      settle();
      chk("reset_quiet", 64'(any_hs()), 64'd0);
      chk("const_fields", {s_arlock, s_arcache, s_arprot, s_awlock, s_awcache, s_awprot}, 64'd0);

      // grant decisions straight out of reset (last_owner = 1, so ties go to m0)
      tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA0, 1'b1, 1'b0};
      tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b0};
      tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hB0, 1'b0, 1'b1};
      tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB4, 1'b0, 1'b1};
      tv[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hB4, 1'b0, 1'b1};
      tv[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA0, 1'b1, 1'b0};
      tv[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b0};
      tv[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA0, 1'b1, 1'b0};
      tv[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
      for (int i = 0; i < 10; i++) begin
         do_reset();
         m0_araddr = 32'hA0; m0_awaddr = 32'hA4; m1_araddr = 32'hB0; m1_awaddr = 32'hB4;
         m0_arvalid = tv[i].m0a; m0_awvalid = tv[i].m0w;
         m1_arvalid = tv[i].m1a; m1_awvalid = tv[i].m1w;
         s_arready = 1; s_awready = 1;
         settle();
         chk($sformatf("v%0d_idle_quiet", i), 64'(any_hs()), 64'd0);
         tick();
         chk($sformatf("v%0d_arvalid", i), 64'(s_arvalid), 64'(tv[i].ea));
         chk($sformatf("v%0d_awvalid", i), 64'(s_awvalid), 64'(tv[i].ew));
         chk($sformatf("v%0d_m0_ready", i), 64'(m0_arready | m0_awready), 64'(tv[i].e0));
         chk($sformatf("v%0d_m1_ready", i), 64'(m1_arready | m1_awready), 64'(tv[i].e1));
         if (tv[i].ea | tv[i].ew)
            chk($sformatf("v%0d_addr", i), tv[i].ew ? s_awaddr : s_araddr, 64'(tv[i].eaddr));
      end

      // single m1 read, then turnaround before an m0 request is forwarded
      do_reset();
      m1_araddr = 32'h1FC00000; m1_arlen = 0; m1_arvalid = 1;
      m0_araddr = 32'h100;
      settle();
      chk("rd_t0_arvalid", 64'(s_arvalid), 64'd0);
      tick();
      s_arready = 1;
      settle();
      chk("rd_t1_arvalid", 64'(s_arvalid), 64'd1);
      chk("rd_araddr", s_araddr, 64'h1FC00000);
      chk("rd_m1_arready", 64'(m1_arready), 64'd1);
      tick();
      m1_arvalid = 0; s_arready = 0;
      s_rvalid = 1; s_rdata = 32'h12345678; s_rlast = 1; s_rid = 4'd2;
      settle();
      chk("rd_m1_rvalid", 64'(m1_rvalid), 64'd1);
      chk("rd_m1_rdata", m1_rdata, 64'h12345678);
      chk("rd_m0_rvalid", 64'(m0_rvalid), 64'd0);
      chk("rd_s_rready", 64'(s_rready), 64'd1);
      tick();
      s_rvalid = 0; s_rlast = 0;
      m0_arvalid = 1;
      settle();
      chk("rd_turnaround_idle", 64'(s_arvalid), 64'd0);
      tick();
      chk("rd_next_arvalid", 64'(s_arvalid), 64'd1);
      chk("rd_next_addr_m0", s_araddr, 64'h100);
      slave_read(1, a);
      m0_arvalid = 0;

      // tie after reset with 16-beat reads, then sustained contention
      do_reset();
      m0_araddr = 32'h100; m1_araddr = 32'h200; m0_arlen = 15; m1_arlen = 15;
      m0_arvalid = 1; m1_arvalid = 1;
      stray = 0;
      slave_read(16, a);
      chk("tie_first_m0", a, 64'h100);
      chk("tie_no_stray_ready", 64'(stray), 64'd0);
      slave_read(16, a);
      chk("tie_second_m1", a, 64'h200);
      slave_read(1, a);
      chk("rr_third_m0", a, 64'h100);
      slave_read(1, a);
      chk("rr_fourth_m1", a, 64'h200);
      m0_arvalid = 0; m1_arvalid = 0;

      // m0 write burst of 16 with slave wready toggling
      do_reset();
      m0_awaddr = 32'h00001000; m0_awlen = 15; m0_awid = 4'd3; m0_awvalid = 1;
      tick();
      s_awready = 1;
      settle();
      chk("wr_awvalid", 64'(s_awvalid), 64'd1);
      chk("wr_awaddr", s_awaddr, 64'h1000);
      chk("wr_awlen", 64'(s_awlen), 64'd15);
      chk("wr_m0_awready", 64'(m0_awready), 64'd1);
      tick();
      m0_awvalid = 0; s_awready = 0; m0_awid = 4'd0;
      acc = 0; beat = 0; cyc = 0; lastbad = 0; databad = 0; lastok = 0; stray = 0;
      while (acc < 16 && cyc < 64) begin
         m0_wvalid = 1;
         m0_wdata  = 32'hA000 + 32'(beat);
         m0_wlast  = (beat == 15);
         s_wready  = (cyc % 2 == 0);
         settle();
         if (s_wvalid && s_wready) begin
            acc++;
            if (s_wlast && acc != 16) lastbad++;
            if (s_wlast && acc == 16) lastok = 1;
            if (s_wdata != 32'hA000 + 32'(beat)) databad++;
         end
         if (m0_wready && m0_wvalid) beat++;
         stray += int'(m1_wready);
         tick();
         cyc++;
      end
      chk("wr_beats", 64'(acc), 64'd16);
      chk("wr_wlast_on_16", 64'(lastok), 64'd1);
      chk("wr_wlast_early", 64'(lastbad), 64'd0);
      chk("wr_wdata", 64'(databad), 64'd0);
      chk("wr_m1_wready", 64'(stray), 64'd0);
      chk("wr_wid_latched", 64'(s_wid), 64'd3);
      s_wready = 1;
      settle();
      chk("wr_wresp_no_wready", 64'(m0_wready), 64'd0);
      m0_wvalid = 0; m0_wlast = 0; s_wready = 0;
      s_bvalid = 1; s_bresp = 2'b00; s_bid = 4'd3;
      settle();
      chk("wr_m0_bvalid", 64'(m0_bvalid), 64'd1);
      chk("wr_m0_bresp", 64'(m0_bresp), 64'd0);
      chk("wr_m0_bid", 64'(m0_bid), 64'd3);
      chk("wr_m1_bvalid", 64'(m1_bvalid), 64'd0);
      chk("wr_s_bready", 64'(s_bready), 64'd1);
      tick();
      s_bvalid = 0;
      settle();
      chk("wr_done_quiet", 64'(any_hs()), 64'd0);

      // slave stall: arready low 5 cycles, handshake on the 6th
      do_reset();
      m1_araddr = 32'h1FC00040; m1_arlen = 0; m1_arvalid = 1;
      tick();
      stable = 0;
      for (int i = 0; i < 5; i++) begin
         s_arready = 0;
         settle();
         if (s_arvalid && s_araddr == 32'h1FC00040 && !m1_arready) stable++;
         tick();
      end
      s_arready = 1;
      settle();
      if (s_arvalid && s_araddr == 32'h1FC00040) stable++;
      chk("stall_stable_cycles", 64'(stable), 64'd6);
      chk("stall_hs_cycle6", 64'(m1_arready), 64'd1);
      tick();
      m1_arvalid = 0; s_arready = 0;
      s_rvalid = 1; s_rlast = 1;
      settle();
      chk("stall_rvalid", 64'(m1_rvalid), 64'd1);
      tick();
      s_rvalid = 0; s_rlast = 0;

      // reset on beat 7 of an m1 16-beat read, then a tie must go to m0
      do_reset();
      m1_araddr = 32'h1FC00080; m1_arlen = 15; m1_arvalid = 1;
      tick();
      s_arready = 1;
      tick();
      m1_arvalid = 0; s_arready = 0;
      for (int i = 0; i < 6; i++) begin
         s_rvalid = 1; s_rdata = 32'(i);
         tick();
      end
      rst = 1;
      tick();
      rst = 0;
      settle();
      chk("rst_mid_quiet", 64'(any_hs()), 64'd0);
      s_rvalid = 0;
      m0_araddr = 32'h100; m1_araddr = 32'h200; m0_arlen = 0; m1_arlen = 0;
      m0_arvalid = 1; m1_arvalid = 1;
      settle();
      chk("rst_mid_idle", 64'(s_arvalid), 64'd0);
      tick();
      chk("rst_tie_arvalid", 64'(s_arvalid), 64'd1);
      chk("rst_tie_m0", s_araddr, 64'h100);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
